// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller in front of data_memory.
// Optional hit/miss counters (stat_hits, stat_misses) are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int CACHE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [CACHE_WIDTH-1:0] cpu_wdata,
  input  logic                   cpu_flush,
  output logic [CACHE_WIDTH-1:0] cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_busy,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [CACHE_WIDTH-1:0] mem_write_data,
  output logic                   mem_memwrite,
`ifdef DCACHE_STATS_EN
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses,
`endif
  input  logic [CACHE_WIDTH-1:0] mem_read_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - 2 - INDEX_BITS;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] MEM_RD  = 2'd2;
  localparam logic [1:0] MEM_WR  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [CACHE_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [CACHE_WIDTH-1:0] rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]  maddr_q, maddr_d;
  logic [CACHE_WIDTH-1:0] mwdata_q, mwdata_d;
  logic                   mwe_q, mwe_d;

  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [CACHE_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   line_we, tag_we;
  logic [CACHE_WIDTH-1:0] line_wdata;

  assign idx = addr_q[2+INDEX_BITS-1:2];
  assign tag = addr_q[ADDR_WIDTH-1:2+INDEX_BITS];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    mwe_d      = mwe_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        // flush has priority; a simultaneous request stays pending on the CPU side
        if (cpu_flush) begin
          valid_d = '0;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (we_q) begin
          maddr_d  = addr_q;
          mwdata_d = wdata_q;
          mwe_d    = 1'b1;
          cnt_d    = CNT_W'(MEM_LATENCY);
          line_we  = hit;
          state_d  = MEM_WR;
        end else if (hit) begin
          rdata_d  = data_mem[idx];
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          maddr_d  = addr_q;
          mwe_d    = 1'b0;
          cnt_d    = CNT_W'(MEM_LATENCY);
          state_d  = MEM_RD;
        end
      end
      MEM_RD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          line_we      = 1'b1;
          tag_we       = 1'b1;
          line_wdata   = mem_read_data;
          valid_d[idx] = 1'b1;
          rdata_d      = mem_read_data;
          ready_d      = 1'b1;
          state_d      = IDLE;
        end
      end
      MEM_WR: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          mwe_d   = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
    end
  end

  // tag/data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (line_we) data_mem[idx] <= line_wdata;
    if (tag_we)  tag_mem[idx]  <= tag;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, misses_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == COMPARE && !we_q) begin
      if (hit) hits_q   <= hits_q + 32'd1;
      else     misses_q <= misses_q + 32'd1;
    end
  end
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

  assign cpu_rdata      = rdata_q;
  assign cpu_ready      = ready_q;
  assign cpu_busy       = (state_q != IDLE);
  assign mem_addr       = maddr_q;
  assign mem_write_data = mwdata_q;
  assign mem_memwrite   = mwe_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic against a
// residency/shadow-memory reference model.
module tb_dcache_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IB  = 6;
  localparam int LAT = 2;
  localparam int MW  = 8192;

  logic          clk, rst_n, cpu_req, cpu_we, cpu_flush;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, mem_write_data, mem_read_data;
  logic          cpu_ready, cpu_busy, mem_memwrite;
`ifdef DCACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses;
`endif

  int n_chk = 0;
  int n_fail = 0;

  dcache_ctrl #(.CACHE_WIDTH(DW), .ADDR_WIDTH(AW), .INDEX_BITS(IB), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_busy(cpu_busy), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite),
`ifdef DCACHE_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .mem_read_data(mem_read_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in: combinational read, write on every edge memwrite is high
  logic [DW-1:0] mem [0:MW-1];
  logic          mem_clr;

  function automatic logic [DW-1:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_val(i);
    end else if (mem_memwrite) begin
      mem[mem_addr[14:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_addr[14:2]];

  // reference model: which word each line holds, plus a shadow of memory contents
  logic [DW-1:0] ref_mem [0:MW-1];
  bit            m_valid [64];
  logic [23:0]   m_tag   [64];
  int            m_hits, m_misses;

  task automatic model(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       output bit hit, output logic [DW-1:0] exp);
    int i;
    i   = int'(a[7:2]);
    hit = m_valid[i] && (m_tag[i] == a[31:8]);
    if (we) begin
      ref_mem[a[14:2]] = wd;
      exp = wd;
    end else begin
      exp = ref_mem[a[14:2]];
      if (hit) m_hits++;
      else begin
        m_misses++;
        m_valid[i] = 1'b1;
        m_tag[i]   = a[31:8];
      end
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // drives one request; latency counts the accept cycle as cycle 1, ready consumed at cycle lat
  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit b2b, output int lat, output logic [DW-1:0] rd,
                        output int wc, output logic [AW-1:0] waddr, output logic [DW-1:0] wdat,
                        output logic [AW-1:0] maddr0, output logic [AW-1:0] maddr1,
                        output logic busy_acc);
    int n;
    if (!b2b) @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    maddr0 = mem_addr;
    @(posedge clk); #1;
    busy_acc = cpu_busy;
    cpu_req = 1'b0;
    n = 0; wc = 0; waddr = '0; wdat = '0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (mem_memwrite) begin
        wc++; waddr = mem_addr; wdat = mem_write_data;
      end
      if (cpu_ready || n > 50) break;
    end
    lat = n + 1;
    rd = cpu_rdata;
    maddr1 = mem_addr;
  endtask

  int            lat, wc;
  logic [DW-1:0] rd, wdat, exp;
  logic [AW-1:0] waddr, ma0, ma1;
  logic          bacc;
  bit            hit;

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_flush = 1'b0;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
    model_flush(); m_hits = 0; m_misses = 0;
    @(posedge clk); @(negedge clk); mem_clr = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", cpu_ready); end
    n_chk++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    n_chk++; if (mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite got=%b exp=0", mem_memwrite); end
    n_chk++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_maddr got=%h exp=0", mem_addr); end
    n_chk++; if (mem_write_data !== '0) begin n_fail++; $display("FAIL reset_mwdata got=%h exp=0", mem_write_data); end
    n_chk++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", cpu_busy); end
`ifdef DCACHE_STATS_EN
    n_chk++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin n_fail++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_hits, stat_misses); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_miss_hit();
    model(1'b0, 32'h100, '0, hit, exp);
    access(1'b0, 32'h100, '0, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (lat != 2 + LAT) begin n_fail++; $display("FAIL miss_lat got=%0d exp=%0d", lat, 2 + LAT); end
    n_chk++; if (rd !== init_val(32'h40)) begin n_fail++; $display("FAIL miss_rdata got=%h exp=%h", rd, init_val(32'h40)); end
    n_chk++; if (ma1 !== 32'h100) begin n_fail++; $display("FAIL miss_maddr got=%h exp=100", ma1); end
    n_chk++; if (wc != 0) begin n_fail++; $display("FAIL miss_memwrite got=%0d cycles exp=0", wc); end
    model(1'b0, 32'h100, '0, hit, exp);
    access(1'b0, 32'h100, '0, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL hit_lat got=%0d exp=2", lat); end
    n_chk++; if (rd !== exp) begin n_fail++; $display("FAIL hit_rdata got=%h exp=%h", rd, exp); end
    n_chk++; if (ma1 !== ma0) begin n_fail++; $display("FAIL hit_maddr got=%h exp=%h", ma1, ma0); end
  endtask

  task automatic test_store_hit();
    model(1'b1, 32'h100, 32'hDEADBEEF, hit, exp);
    access(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (wc != LAT) begin n_fail++; $display("FAIL sthit_memwrite got=%0d cycles exp=%0d", wc, LAT); end
    n_chk++; if (waddr !== 32'h100 || wdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sthit_bus got=%h/%h exp=100/deadbeef", waddr, wdat); end
    n_chk++; if (lat != 2 + LAT) begin n_fail++; $display("FAIL sthit_lat got=%0d exp=%0d", lat, 2 + LAT); end
    model(1'b0, 32'h100, '0, hit, exp);
    access(1'b0, 32'h100, '0, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (lat != 2 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sthit_reload got=%0d/%h exp=2/deadbeef", lat, rd); end
  endtask

  task automatic test_store_miss();
    model(1'b1, 32'h200, 32'h12345678, hit, exp);
    access(1'b1, 32'h200, 32'h12345678, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (wc != LAT || waddr !== 32'h200 || wdat !== 32'h12345678) begin n_fail++; $display("FAIL stmiss_bus got=%0d/%h/%h exp=%0d/200/12345678", wc, waddr, wdat, LAT); end
    model(1'b0, 32'h200, '0, hit, exp);
    access(1'b0, 32'h200, '0, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (lat != 2 + LAT || rd !== 32'h12345678) begin n_fail++; $display("FAIL stmiss_reload got=%0d/%h exp=%0d/12345678", lat, rd, 2 + LAT); end
  endtask

  task automatic test_evict();
    logic [AW-1:0] seq [3];
    seq[0] = 32'h100; seq[1] = 32'h4100; seq[2] = 32'h100;
    for (int k = 0; k < 3; k++) begin
      model(1'b0, seq[k], '0, hit, exp);
      access(1'b0, seq[k], '0, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
      n_chk++; if (lat != 2 + LAT || rd !== exp || ma1 !== seq[k]) begin n_fail++; $display("FAIL evict_%0d got=%0d/%h/%h exp=%0d/%h/%h", k, lat, rd, ma1, 2 + LAT, exp, seq[k]); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    cpu_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    @(posedge clk); #1;
    n_chk++; if (cpu_busy !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_noaccept got=%b/%b exp=0/0", cpu_busy, cpu_ready); end
    cpu_flush = 1'b0;
    model_flush();
    model(1'b0, 32'h100, '0, hit, exp);
    access(1'b0, 32'h100, '0, 1'b1, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (lat != 2 + LAT || rd !== exp) begin n_fail++; $display("FAIL flush_reload got=%0d/%h exp=%0d/%h", lat, rd, 2 + LAT, exp); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] seq [4];
    seq[0] = 32'h104; seq[1] = 32'h108; seq[2] = 32'h104; seq[3] = 32'h108;
    for (int k = 0; k < 4; k++) begin
      model(1'b0, seq[k], '0, hit, exp);
      access(1'b0, seq[k], '0, (k != 0), lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
      n_chk++; if (bacc !== 1'b1 || lat != (hit ? 2 : 2 + LAT) || rd !== exp) begin n_fail++; $display("FAIL b2b_%0d got=%b/%0d/%h exp=1/%0d/%h", k, bacc, lat, rd, hit ? 2 : 2 + LAT, exp); end
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (mem_memwrite !== 1'b1) begin n_fail++; $display("FAIL midwr_memwrite_hi got=%b exp=1", mem_memwrite); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (mem_memwrite !== 1'b0 || cpu_ready !== 1'b0 || cpu_busy !== 1'b0) begin n_fail++; $display("FAIL midwr_abort got=%b/%b/%b exp=0/0/0", mem_memwrite, cpu_ready, cpu_busy); end
    @(negedge clk); rst_n = 1'b1;
    // the bus write was in flight on the edge that reset landed on
    ref_mem[32'h300 >> 2] = 32'hCAFEF00D;
    model_flush(); m_hits = 0; m_misses = 0;
    model(1'b0, 32'h100, '0, hit, exp);
    access(1'b0, 32'h100, '0, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
    n_chk++; if (lat != 2 + LAT || rd !== exp) begin n_fail++; $display("FAIL midwr_reload got=%0d/%h exp=%0d/%h", lat, rd, 2 + LAT, exp); end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(15) == 0) begin
        @(negedge clk); cpu_flush = 1'b1;
        @(negedge clk); cpu_flush = 1'b0;
        model_flush();
      end
      we = ($urandom_range(3) == 0);
      a  = {22'd0, 2'($urandom_range(3)), 3'd0, 3'($urandom_range(7)), 2'($urandom_range(3))};
      wd = $urandom;
      model(we, a, wd, hit, exp);
      access(we, a, wd, 1'b0, lat, rd, wc, waddr, wdat, ma0, ma1, bacc);
      if (we) begin
        n_chk++; if (lat != 2 + LAT || wc != LAT || waddr !== a || wdat !== wd) begin n_fail++; $display("FAIL rnd_st_%0d a=%h got=%0d/%0d/%h/%h exp=%0d/%0d/%h/%h", k, a, lat, wc, waddr, wdat, 2 + LAT, LAT, a, wd); end
      end else begin
        n_chk++; if (lat != (hit ? 2 : 2 + LAT) || wc != 0 || rd !== exp) begin n_fail++; $display("FAIL rnd_ld_%0d a=%h got=%0d/%0d/%h exp=%0d/0/%h", k, a, lat, wc, rd, hit ? 2 : 2 + LAT, exp); end
      end
    end
`ifdef DCACHE_STATS_EN
    n_chk++; if (stat_hits !== 32'(m_hits) || stat_misses !== 32'(m_misses)) begin n_fail++; $display("FAIL stats got=%0d/%0d exp=%0d/%0d", stat_hits, stat_misses, m_hits, m_misses); end
`endif
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_store_hit();
    test_store_miss();
    test_evict();
    test_flush();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
